memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/srv1_pkg.sv | 32 +++
 rtl/mem_align.sv | 46 ++++
 rtl/memory_stage.sv | 152 +++++++++++++++
 tb/tb_memory_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/srv1_pkg.sv
// srv1_pkg: control-word bit positions, writeback select, load/store funct3 codes and memory FSM states.
// Shared by memory_stage and mem_align.
package srv1_pkg;
    localparam int CTR_MEM_RD = 0;
    localparam int CTR_MEM_WR = 1;
    localparam int CTR_REG_WR = 2;
    localparam int CTR_WB_LO  = 3;
    localparam int CTR_WB_HI  = 4;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LOAD   = 2'd1,
        WB_INC_PC = 2'd2,
        WB_RSVD   = 2'd3
    } wb_sel_t;

    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE     = 1'b0;
    localparam state_t ST_WAIT_ACK = 1'b1;

    // fn3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] fn3, input logic [1:0] a);
        return ((fn3[1:0] == FN3_H[1:0]) && a[0]) ||
               ((fn3[1:0] == FN3_W[1:0]) && (a != 2'b00));
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store byte-lane replication/enables and load lane extraction with sign/zero extension.
// Latency: combinational. Backpressure: none.
// Flow control: none (pure function of its inputs).
module mem_align
    import srv1_pkg::*;
(
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = load_word[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        wdata = store_data;
        be    = 4'b0000;
        case (fn3)
            FN3_B: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            FN3_H: begin
                wdata = {2{store_data[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            FN3_W:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        case (fn3)
            FN3_B:   load_data = {{24{ld_byte[7]}}, ld_byte};
            FN3_H:   load_data = {{16{ld_half[15]}}, ld_half};
            FN3_W:   load_data = load_word;
            FN3_BU:  load_data = {24'd0, ld_byte};
            FN3_HU:  load_data = {16'd0, ld_half};
            default: load_data = 32'd0;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: data-bus access, alignment and writeback buffer; MEM_MISALIGN_TRAP_EN enables the misalignment trap.
// Latency: non-memory ops reach wb_* after 1 cycle, memory ops on the edge after the dbus_ack cycle.
// Backpressure: stall_out holds upstream while a bus access waits for dbus_ack; clk_en freezes everything.
module memory_stage
    import srv1_pkg::*;
(
    input  logic        clk,
    input  logic        sync_rst_n,
    input  logic        clk_en,
    input  logic        invalidate,
    input  logic [4:0]  ctr_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_in,
    input  logic [29:0] inc_pc_in,
    input  logic [31:0] rs2_data_in,
    input  logic        branch_taken_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [29:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        redirect_valid,
    output logic [29:0] redirect_pc,
    output logic        stall_out,
    output logic [4:0]  mem_rd_address,
    output logic        mem_writes_rd,
    output logic        wb_reg_wr,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_out
`endif
);
    state_t      state;
    wb_sel_t     wb_sel;
    logic        rd_op, wr_op, mem_op, misalign, in_wait, issue, upd, kill, kill_pend;
    logic [2:0]  fn3;
    logic [4:0]  rd;
    logic [31:0] fmt_wdata, load_data, wb_next;
    logic [3:0]  fmt_be;
    logic        hold_we;
    logic [29:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_be;
    logic        unused_inst;

    assign rd_op  = ctr_in[CTR_MEM_RD];
    assign wr_op  = ctr_in[CTR_MEM_WR];
    assign wb_sel = wb_sel_t'(ctr_in[CTR_WB_HI:CTR_WB_LO]);
    assign fn3    = inst_in[14:12];
    assign rd     = inst_in[11:7];
    assign unused_inst = &{1'b0, inst_in[31:15], inst_in[6:0]};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (rd_op | wr_op) & is_misaligned(fn3, alu_in[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // A trapped access never touches the bus, so it must not stall either.
    assign mem_op  = (rd_op | wr_op) & ~misalign;
    assign in_wait = (state == ST_WAIT_ACK);
    assign issue   = ~in_wait & mem_op & clk_en;

    assign dbus_req   = sync_rst_n & (issue | in_wait);
    assign dbus_we    = in_wait ? hold_we    : wr_op;
    assign dbus_addr  = in_wait ? hold_addr  : alu_in[31:2];
    assign dbus_wdata = in_wait ? hold_wdata : fmt_wdata;
    assign dbus_be    = in_wait ? hold_be    : fmt_be;

    assign stall_out      = (mem_op | in_wait) & ~dbus_ack;
    assign upd            = clk_en & ~stall_out;
    assign kill           = invalidate | kill_pend;
    assign redirect_valid = branch_taken_in;
    assign redirect_pc    = alu_in[31:2];
    assign mem_rd_address = rd;
    assign mem_writes_rd  = ctr_in[CTR_REG_WR] & (rd != 5'd0);

    mem_align u_align (
        .fn3        (fn3),
        .addr_lo    (alu_in[1:0]),
        .store_data (rs2_data_in),
        .load_word  (dbus_rdata),
        .wdata      (fmt_wdata),
        .be         (fmt_be),
        .load_data  (load_data)
    );

    always_comb begin
        wb_next = alu_in;
        case (wb_sel)
            WB_LOAD:   wb_next = load_data;
            WB_INC_PC: wb_next = {inc_pc_in, 2'b00};
            default:   wb_next = alu_in;
        endcase
    end

    // The ack is only consumed while clk_en is high; the bus request stays up until then.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            if (!in_wait && mem_op && !dbus_ack)
                state <= ST_WAIT_ACK;
            else if (in_wait && dbus_ack)
                state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst_n && issue && !dbus_ack) begin
            hold_we    <= wr_op;
            hold_addr  <= alu_in[31:2];
            hold_wdata <= fmt_wdata;
            hold_be    <= fmt_be;
        end
    end

    // An invalidate seen while stalled must still kill the result when it finally lands.
    always_ff @(posedge clk) begin
        if (!sync_rst_n)
            kill_pend <= 1'b0;
        else if (upd)
            kill_pend <= 1'b0;
        else if (invalidate)
            kill_pend <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            wb_reg_wr <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
        end else if (upd) begin
            wb_reg_wr <= mem_writes_rd & ~kill & ~misalign;
            wb_rd     <= rd;
            wb_data   <= wb_next;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!sync_rst_n)
            misalign_out <= 1'b0;
        else if (upd)
            misalign_out <= misalign;
    end
`endif
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vector table for single-cycle behaviour plus hand sequences for waits, reset, invalidate and clk_en.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        sync_rst_n, clk_en, invalidate;
    logic [4:0]  ctr_in;
    logic [31:0] inst_in, alu_in, rs2_data_in, dbus_rdata;
    logic [29:0] inc_pc_in;
    logic        branch_taken_in, dbus_ack;
    logic        dbus_req, dbus_we, redirect_valid, stall_out, mem_writes_rd, wb_reg_wr;
    logic [29:0] dbus_addr, redirect_pc;
    logic [31:0] dbus_wdata, wb_data;
    logic [3:0]  dbus_be;
    logic [4:0]  mem_rd_address, wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_out;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .invalidate(invalidate),
        .ctr_in(ctr_in), .inst_in(inst_in), .alu_in(alu_in), .inc_pc_in(inc_pc_in),
        .rs2_data_in(rs2_data_in), .branch_taken_in(branch_taken_in),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_out(stall_out),
        .mem_rd_address(mem_rd_address), .mem_writes_rd(mem_writes_rd),
        .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_out(misalign_out)
`endif
    );

    typedef struct {
        string       name;
        logic [4:0]  ctr;
        logic [31:0] inst, alu;
        logic [29:0] inc;
        logic [31:0] rs2;
        logic        br;
        logic [31:0] rdata;
        logic        e_req;
        logic [29:0] e_addr;
        logic        chk_bus, e_we;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_wbrw;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    function automatic logic [4:0] C(input logic [1:0] sel, input logic rw, input logic mw, input logic mr);
        return {sel, rw, mw, mr};
    endfunction

    function automatic logic [31:0] I(input logic [2:0] f, input logic [4:0] r);
        return {17'd0, f, r, 7'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input string nm, input logic [4:0] c, input logic [31:0] ins, input logic [31:0] a,
                       input logic [29:0] inc, input logic [31:0] r2, input logic br, input logic [31:0] rdat,
                       input logic req, input logic [29:0] addr, input logic cb, input logic we,
                       input logic [31:0] wd, input logic [3:0] be, input logic wbrw, input logic [4:0] r,
                       input logic [31:0] d);
        vec_t v;
        v.name = nm; v.ctr = c; v.inst = ins; v.alu = a; v.inc = inc; v.rs2 = r2; v.br = br;
        v.rdata = rdat; v.e_req = req; v.e_addr = addr; v.chk_bus = cb; v.e_we = we;
        v.e_wdata = wd; v.e_be = be; v.e_wbrw = wbrw; v.e_rd = r; v.e_data = d;
        vq.push_back(v);
    endtask

    task automatic set_in(input logic [4:0] c, input logic [31:0] ins, input logic [31:0] a,
                          input logic [29:0] inc, input logic [31:0] r2, input logic br,
                          input logic [31:0] rdat, input logic ack);
        ctr_in = c; inst_in = ins; alu_in = a; inc_pc_in = inc; rs2_data_in = r2;
        branch_taken_in = br; dbus_rdata = rdat; dbus_ack = ack;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        add("alu",    C(0,1,0,0), I(0,5), 32'h12345678, 30'h0,  32'h0,        0, 32'h0,        0, 30'h048D159E, 0, 0, 32'h0,        4'h0, 1, 5'd5, 32'h12345678);
        add("sw",     C(0,0,1,0), I(2,0), 32'h00000100, 30'h0,  32'hDEADBEEF, 0, 32'h0,        1, 30'h40,       1, 1, 32'hDEADBEEF, 4'hF, 0, 5'd0, 32'h00000100);
        add("lhu",    C(1,1,0,1), I(5,7), 32'h00000102, 30'h0,  32'h0,        0, 32'h80AABBCC, 1, 30'h40,       0, 0, 32'h0,        4'h0, 1, 5'd7, 32'h000080AA);
        add("sh",     C(0,0,1,0), I(1,0), 32'h00000102, 30'h0,  32'h00001234, 0, 32'h0,        1, 30'h40,       1, 1, 32'h12341234, 4'hC, 0, 5'd0, 32'h00000102);
        add("sb",     C(0,0,1,0), I(0,0), 32'h00000101, 30'h0,  32'h000000A5, 0, 32'h0,        1, 30'h40,       1, 1, 32'hA5A5A5A5, 4'h2, 0, 5'd0, 32'h00000101);
        add("jal",    C(2,1,0,0), I(0,1), 32'h00000200, 30'h40, 32'h0,        1, 32'h0,        0, 30'h80,       0, 0, 32'h0,        4'h0, 1, 5'd1, 32'h00000100);
        add("jal_x0", C(2,1,0,0), I(0,0), 32'h00000200, 30'h40, 32'h0,        1, 32'h0,        0, 30'h80,       0, 0, 32'h0,        4'h0, 0, 5'd0, 32'h00000100);
        add("lb",     C(1,1,0,1), I(0,3), 32'h00000100, 30'h0,  32'h0,        0, 32'h80AABBCC, 1, 30'h40,       0, 0, 32'h0,        4'h0, 1, 5'd3, 32'hFFFFFFCC);
        add("lh",     C(1,1,0,1), I(1,3), 32'h00000100, 30'h0,  32'h0,        0, 32'h80AABBCC, 1, 30'h40,       0, 0, 32'h0,        4'h0, 1, 5'd3, 32'hFFFFBBCC);
        add("lw",     C(1,1,0,1), I(2,3), 32'h00000104, 30'h0,  32'h0,        0, 32'h80AABBCC, 1, 30'h41,       0, 0, 32'h0,        4'h0, 1, 5'd3, 32'h80AABBCC);
        add("lbu",    C(1,1,0,1), I(4,3), 32'h00000102, 30'h0,  32'h0,        0, 32'h80AABBCC, 1, 30'h40,       0, 0, 32'h0,        4'h0, 1, 5'd3, 32'h000000AA);
        add("rsvd",   C(3,1,0,0), I(0,2), 32'hCAFEF00D, 30'h0,  32'h0,        0, 32'h0,        0, 30'h32BFBC03, 0, 0, 32'h0,        4'h0, 1, 5'd2, 32'hCAFEF00D);
        add("ld_bad", C(1,1,0,1), I(3,3), 32'h00000100, 30'h0,  32'h0,        0, 32'h80AABBCC, 1, 30'h40,       0, 0, 32'h0,        4'h0, 1, 5'd3, 32'h00000000);

        // Reset: mem op on the inputs, request must still be forced low.
        sync_rst_n = 1'b0; clk_en = 1'b1; invalidate = 1'b0;
        set_in(C(1,1,0,1), I(2,4), 32'h100, 30'h0, 32'h0, 1, 32'h0, 0);
        @(posedge clk); @(negedge clk); #1;
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd1);
        chk("rst_redir_v", 32'(redirect_valid), 32'd1);
        chk("rst_redir_pc", 32'(redirect_pc), 32'h40);
        @(posedge clk); #1;
        chk("rst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(misalign_out), 32'd0);
`endif
        @(negedge clk);
        sync_rst_n = 1'b1;
        set_in(5'd0, 32'd0, 32'd0, 30'd0, 32'd0, 0, 32'd0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            set_in(v.ctr, v.inst, v.alu, v.inc, v.rs2, v.br, v.rdata, 1'b1);
            #1;
            chk({v.name, ".req"}, 32'(dbus_req), 32'(v.e_req));
            chk({v.name, ".addr"}, 32'(dbus_addr), 32'(v.e_addr));
            chk({v.name, ".stall"}, 32'(stall_out), 32'd0);
            chk({v.name, ".redir_v"}, 32'(redirect_valid), 32'(v.br));
            chk({v.name, ".redir_pc"}, 32'(redirect_pc), 32'(v.alu[31:2]));
            chk({v.name, ".mem_rd_addr"}, 32'(mem_rd_address), 32'(v.e_rd));
            chk({v.name, ".mem_writes_rd"}, 32'(mem_writes_rd), 32'(v.e_wbrw));
            if (v.chk_bus) begin
                chk({v.name, ".we"}, 32'(dbus_we), 32'(v.e_we));
                chk({v.name, ".wdata"}, dbus_wdata, v.e_wdata);
                chk({v.name, ".be"}, 32'(dbus_be), 32'(v.e_be));
            end
            @(posedge clk); #1;
            chk({v.name, ".wb_reg_wr"}, 32'(wb_reg_wr), 32'(v.e_wbrw));
            chk({v.name, ".wb_rd"}, 32'(wb_rd), 32'(v.e_rd));
            chk({v.name, ".wb_data"}, wb_data, v.e_data);
`ifdef MEM_MISALIGN_TRAP_EN
            chk({v.name, ".misalign"}, 32'(misalign_out), 32'd0);
`endif
        end

        // LB with ack after 3 stalled cycles; address must stay held in WAIT_ACK.
        @(negedge clk);
        set_in(C(1,1,0,1), I(0,9), 32'h103, 30'h0, 32'h0, 0, 32'h0, 0);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) alu_in = 32'h203;
            #1;
            chk("lbw.req", 32'(dbus_req), 32'd1);
            chk("lbw.addr", 32'(dbus_addr), 32'h40);
            chk("lbw.stall", 32'(stall_out), 32'd1);
            @(posedge clk); #1;
            chk("lbw.wb_hold", 32'(wb_rd), 32'd3);
            @(negedge clk);
        end
        alu_in = 32'h103; dbus_ack = 1'b1; dbus_rdata = 32'h80AABBCC;
        #1;
        chk("lbw.ack_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("lbw.wb_data", wb_data, 32'hFFFFFF80);
        chk("lbw.wb_rd", 32'(wb_rd), 32'd9);
        chk("lbw.wb_reg_wr", 32'(wb_reg_wr), 32'd1);

        // Invalidate while waiting: bus access continues, result discarded.
        @(negedge clk);
        set_in(C(1,1,0,1), I(2,6), 32'h100, 30'h0, 32'h0, 0, 32'h0, 0);
        #1 chk("inv.req0", 32'(dbus_req), 32'd1);
        @(negedge clk);
        invalidate = 1'b1;
        #1 chk("inv.req1", 32'(dbus_req), 32'd1);
        @(negedge clk);
        invalidate = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'h11111111;
        #1 chk("inv.req2", 32'(dbus_req), 32'd1);
        @(posedge clk); #1;
        chk("inv.wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        chk("inv.wb_rd", 32'(wb_rd), 32'd6);
        chk("inv.wb_data", wb_data, 32'h11111111);

        // clk_en low freezes the buffer and keeps an outstanding request up.
        @(negedge clk);
        clk_en = 1'b0;
        set_in(C(0,1,0,0), I(0,10), 32'h55, 30'h0, 32'h0, 0, 32'h0, 1);
        @(posedge clk); #1;
        chk("frz.alu_wb_rd", 32'(wb_rd), 32'd6);
        @(negedge clk);
        clk_en = 1'b1;
        set_in(C(1,1,0,1), I(2,11), 32'h104, 30'h0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        clk_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1 chk("frz.req", 32'(dbus_req), 32'd1);
            @(posedge clk); #1;
            chk("frz.wb_rd", 32'(wb_rd), 32'd6);
            @(negedge clk);
        end
        clk_en = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h22222222;
        @(posedge clk); #1;
        chk("frz.wb_rd_done", 32'(wb_rd), 32'd11);
        chk("frz.wb_data", wb_data, 32'h22222222);

        // Reset in WAIT_ACK, then a late ack with a non-memory op.
        @(negedge clk);
        set_in(C(0,0,1,0), I(2,0), 32'h100, 30'h0, 32'h0, 0, 32'h0, 0);
        #1 chk("rstw.req_issue", 32'(dbus_req), 32'd1);
        @(negedge clk);
        sync_rst_n = 1'b0;
        #1 chk("rstw.req_in_rst", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        chk("rstw.wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        chk("rstw.wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        sync_rst_n = 1'b1;
        set_in(C(0,1,0,0), I(0,4), 32'h44, 30'h0, 32'h0, 0, 32'h0, 1);
        #1;
        chk("rstw.req_after", 32'(dbus_req), 32'd0);
        chk("rstw.stall_after", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("rstw.wb_rd_after", 32'(wb_rd), 32'd4);
        chk("rstw.wb_reg_wr_after", 32'(wb_reg_wr), 32'd1);
        chk("rstw.wb_data_after", wb_data, 32'h44);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW traps: no request, flag for one update only.
        @(negedge clk);
        set_in(C(1,1,0,1), I(2,5), 32'h102, 30'h0, 32'h0, 0, 32'h0, 0);
        #1;
        chk("mis.req", 32'(dbus_req), 32'd0);
        chk("mis.stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("mis.flag", 32'(misalign_out), 32'd1);
        chk("mis.wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        @(negedge clk);
        set_in(C(0,1,0,0), I(0,5), 32'h8, 30'h0, 32'h0, 0, 32'h0, 0);
        @(posedge clk); #1;
        chk("mis.flag_clear", 32'(misalign_out), 32'd0);
        chk("mis.wb_reg_wr_next", 32'(wb_reg_wr), 32'd1);
`else
        // Without the trap a misaligned LW simply accesses the containing word.
        @(negedge clk);
        set_in(C(1,1,0,1), I(2,5), 32'h102, 30'h0, 32'h0, 0, 32'h80AABBCC, 1);
        #1;
        chk("mis.req", 32'(dbus_req), 32'd1);
        chk("mis.addr", 32'(dbus_addr), 32'h40);
        @(posedge clk); #1;
        chk("mis.wb_data", wb_data, 32'h80AABBCC);
        chk("mis.wb_reg_wr", 32'(wb_reg_wr), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
